// File: rtl/ahb_arb_fsm_pkg.sv
// ahb_arb_fsm_pkg: shared types for the AHB manager arbiter.
//   cvw_t       - configuration record (bus width, burst enable, line sizes)
//   ahbtrans_t  - HTRANS encodings (IDLE/NONSEQ/SEQ)
//   SINGLE..INCR16 - HBURST encodings
//   arbstate_t  - arbiter FSM states
//   burst_enc() - beat count (minus one) to HBURST
package ahb_arb_fsm_pkg;

    typedef struct packed {
        int unsigned AHBW;
        logic        BURST_EN;
        int unsigned ICACHE_LINELENINBITS;
        int unsigned DCACHE_LINELENINBITS;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{
        AHBW: 64,
        BURST_EN: 1'b1,
        ICACHE_LINELENINBITS: 512,
        DCACHE_LINELENINBITS: 256
    };

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } ahbtrans_t;

    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR4  = 3'b011;
    localparam logic [2:0] INCR8  = 3'b101;
    localparam logic [2:0] INCR16 = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } arbstate_t;

    // Only 1/4/8/16 beats have an encoding; anything else falls back to SINGLE.
    function automatic logic [2:0] burst_enc(input logic [3:0] beats_m1);
        case (beats_m1)
            4'd3:    return INCR4;
            4'd7:    return INCR8;
            4'd15:   return INCR16;
            default: return SINGLE;
        endcase
    endfunction

endpackage

// File: rtl/ahb_arb_fsm_if.sv
// ahb_arb_fsm_if: requester handshakes plus the AHB manager control signals.
//   master - arbiter side: takes requests/HREADY, drives grants, dones,
//            HTRANS, HBURST, Sel, AddrBeat
//   slave  - environment side (requesters and subordinate)
interface ahb_arb_fsm_if;
    import ahb_arb_fsm_pkg::*;

    logic       IFUReq;
    logic       IFUBurst;
    logic       IFUGrant;
    logic       IFUDone;
    logic       LSUReq;
    logic       LSUBurst;
    logic       LSUGrant;
    logic       LSUDone;
    logic       HREADY;
    ahbtrans_t  HTRANS;
    logic [2:0] HBURST;
    logic       Sel;
    logic [3:0] AddrBeat;

    modport master (
        input  IFUReq, IFUBurst, LSUReq, LSUBurst, HREADY,
        output IFUGrant, IFUDone, LSUGrant, LSUDone, HTRANS, HBURST, Sel, AddrBeat
    );

    modport slave (
        output IFUReq, IFUBurst, LSUReq, LSUBurst, HREADY,
        input  IFUGrant, IFUDone, LSUGrant, LSUDone, HTRANS, HBURST, Sel, AddrBeat
    );

endinterface

// File: rtl/ahb_arb_fsm_beat_ctr.sv
// ahb_beat_ctr: loadable 4-bit beat counter with last-beat compare.
//   clk, reset - clock, synchronous active-high reset
//   load       - load load_val (has priority over en)
//   en         - increment by one
//   last_val   - value that marks the final beat
//   cnt        - current beat index
//   last       - cnt == last_val
module ahb_beat_ctr (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       en,
    input  logic [3:0] load_val,
    input  logic [3:0] last_val,
    output logic [3:0] cnt,
    output logic       last
);

    always_ff @(posedge clk) begin
        if (reset)     cnt <= 4'd0;
        else if (load) cnt <= load_val;
        else if (en)   cnt <= cnt + 4'd1;
    end

    assign last = (cnt == last_val);

endmodule

// File: rtl/ahb_arb_fsm.sv
// ahb_arb_fsm: two-requester (IFU/LSU) AHB manager arbiter and transfer
// sequencer. Picks a winner in IDLE, issues one or a line's worth of address
// phases in ADDR (counting beats against HREADY), then waits for the final
// data phase in DATA and pulses the winner's Done.
//   clk, reset - clock, synchronous active-high reset
//   bus        - ahb_arb_fsm_if.master: requests/bursts, HREADY in;
//                grants, dones, HTRANS, HBURST, Sel, AddrBeat out
// Parameter P (cvw_t) supplies AHBW, BURST_EN and the I/D line lengths.
// Optional macro WALLY_ARB_STARVE_GUARD_EN: after three LSU wins over a
// pending IFU, the next contended arbitration goes to the IFU.
module ahb_arb_fsm
    import ahb_arb_fsm_pkg::*;
#(
    parameter cvw_t P = CVW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    ahb_arb_fsm_if.master bus
);

    localparam int IBEATS = int'(P.ICACHE_LINELENINBITS / P.AHBW);
    localparam int DBEATS = int'(P.DCACHE_LINELENINBITS / P.AHBW);
    localparam logic [3:0] IBEATS_M1 = 4'(IBEATS - 1);
    localparam logic [3:0] DBEATS_M1 = 4'(DBEATS - 1);

    arbstate_t  state, next_state;
    logic       sel_q;
    logic [3:0] beats_m1_q;
    logic       any_req, pick_lsu, force_ifu, win_burst;
    logic [3:0] win_beats_m1;
    logic [3:0] beat;
    logic       beat_last;

    assign any_req = bus.IFUReq | bus.LSUReq;

`ifdef WALLY_ARB_STARVE_GUARD_EN
    // Counts LSU wins taken while the IFU was also waiting.
    logic [1:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 2'd0;
        end else if (state == ST_IDLE && any_req) begin
            if (!pick_lsu)       starve_cnt <= 2'd0;
            else if (bus.IFUReq) starve_cnt <= starve_cnt + 2'd1;
        end
    end

    assign force_ifu = (starve_cnt == 2'd3) && bus.IFUReq && bus.LSUReq;
`else
    assign force_ifu = 1'b0;
`endif

    assign pick_lsu     = bus.LSUReq && !force_ifu;
    assign win_burst    = pick_lsu ? bus.LSUBurst : bus.IFUBurst;
    assign win_beats_m1 = win_burst ? (pick_lsu ? DBEATS_M1 : IBEATS_M1) : 4'd0;

    // Winner and length are frozen at arbitration; requests are only
    // looked at again once the FSM is back in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q      <= 1'b0;
            beats_m1_q <= 4'd0;
        end else if (state == ST_IDLE && any_req) begin
            sel_q      <= pick_lsu;
            beats_m1_q <= win_beats_m1;
        end
    end

    // Held at zero in IDLE; stops on the last beat so it never wraps.
    ahb_beat_ctr u_beat_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (state == ST_IDLE),
        .en       (state == ST_ADDR && bus.HREADY && !beat_last),
        .load_val (4'd0),
        .last_val (beats_m1_q),
        .cnt      (beat),
        .last     (beat_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: if (any_req)                   next_state = ST_ADDR;
            ST_ADDR: if (bus.HREADY && beat_last)   next_state = ST_DATA;
            ST_DATA: if (bus.HREADY)                next_state = ST_IDLE;
            default:                                next_state = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.HTRANS   = IDLE;
        bus.HBURST   = SINGLE;
        bus.IFUGrant = (state != ST_IDLE) && !sel_q;
        bus.LSUGrant = (state != ST_IDLE) &&  sel_q;
        bus.IFUDone  = 1'b0;
        bus.LSUDone  = 1'b0;
        bus.Sel      = sel_q;
        bus.AddrBeat = beat;
        unique case (state)
            ST_ADDR: begin
                // Without burst support every beat is its own NONSEQ SINGLE.
                bus.HTRANS = (beat == 4'd0 || !P.BURST_EN) ? NONSEQ : SEQ;
                bus.HBURST = P.BURST_EN ? burst_enc(beats_m1_q) : SINGLE;
            end
            ST_DATA: begin
                // A transfer abandoned by reset must not report completion.
                bus.IFUDone = bus.HREADY && !reset && !sel_q;
                bus.LSUDone = bus.HREADY && !reset &&  sel_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_arb_fsm.sv
// Scoreboard bench for ahb_arb_fsm. Two DUTs share stimulus: b0 with bursts
// enabled and b1 with BURST_EN=0 (same timing, every beat NONSEQ/SINGLE).
// Config: AHBW=64, I-line 512 (8 beats), D-line 256 (4 beats).
module tb_ahb_arb_fsm;
    import ahb_arb_fsm_pkg::*;

    localparam cvw_t CFG0 = '{AHBW: 64, BURST_EN: 1'b1,
                              ICACHE_LINELENINBITS: 512, DCACHE_LINELENINBITS: 256};
    localparam cvw_t CFG1 = '{AHBW: 64, BURST_EN: 1'b0,
                              ICACHE_LINELENINBITS: 512, DCACHE_LINELENINBITS: 256};

    typedef struct {
        int         cyc;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       sel;
        logic [3:0] beat;
    } addr_exp_t;

    typedef struct {
        int   cyc;
        logic sel;
    } done_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic IFUReq = 1'b0, IFUBurst = 1'b0, LSUReq = 1'b0, LSUBurst = 1'b0;
    logic HREADY = 1'b1;

    int        cyc = 0;
    int        n_cmp = 0, n_bad = 0;
    bit        mon_en = 1'b0;
    bit        saw_ifu = 1'b0, saw_lsu = 1'b0;
    addr_exp_t aq[$];
    done_exp_t dq[$];

    ahb_arb_fsm_if b0 ();
    ahb_arb_fsm_if b1 ();

    assign b0.IFUReq = IFUReq;   assign b1.IFUReq = IFUReq;
    assign b0.IFUBurst = IFUBurst; assign b1.IFUBurst = IFUBurst;
    assign b0.LSUReq = LSUReq;   assign b1.LSUReq = LSUReq;
    assign b0.LSUBurst = LSUBurst; assign b1.LSUBurst = LSUBurst;
    assign b0.HREADY = HREADY;   assign b1.HREADY = HREADY;

    ahb_arb_fsm #(.P(CFG0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    ahb_arb_fsm #(.P(CFG1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d want finish", cyc);
        $fatal(1, "watchdog");
    end

    function automatic void ea(int c, logic [1:0] tr, logic [2:0] bu, logic s, logic [3:0] b);
        addr_exp_t e;
        e.cyc = c; e.trans = tr; e.burst = bu; e.sel = s; e.beat = b;
        aq.push_back(e);
    endfunction

    function automatic void ed(int c, logic s);
        done_exp_t e;
        e.cyc = c; e.sel = s;
        dq.push_back(e);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever a DUT shows an address phase or Done.
    always @(negedge clk) begin
        addr_exp_t a;
        done_exp_t d;
        if (mon_en) begin
            if (b0.HTRANS != IDLE)
                assert (b0.HBURST inside {SINGLE, INCR4, INCR8, INCR16});
            if (b0.HTRANS != IDLE || b1.HTRANS != IDLE) begin
                n_cmp++;
                if (aq.size() == 0) begin
                    n_bad++;
                    $display("FAIL addr_unexpected cyc=%0d trans0=%b trans1=%b", cyc, b0.HTRANS, b1.HTRANS);
                end else begin
                    a = aq.pop_front();
                    if (cyc != a.cyc || b0.HTRANS != a.trans || b0.HBURST != a.burst ||
                        b0.Sel != a.sel || b0.AddrBeat != a.beat ||
                        b0.IFUGrant != !a.sel || b0.LSUGrant != a.sel) begin
                        n_bad++;
                        $display("FAIL addr_burst got cyc=%0d tr=%b hb=%b sel=%b beat=%0d ig=%b lg=%b want cyc=%0d tr=%b hb=%b sel=%b beat=%0d",
                                 cyc, b0.HTRANS, b0.HBURST, b0.Sel, b0.AddrBeat, b0.IFUGrant, b0.LSUGrant,
                                 a.cyc, a.trans, a.burst, a.sel, a.beat);
                    end
                    n_cmp++;
                    if (b1.HTRANS != NONSEQ || b1.HBURST != SINGLE || b1.Sel != a.sel ||
                        b1.AddrBeat != a.beat || b1.IFUGrant != !a.sel || b1.LSUGrant != a.sel) begin
                        n_bad++;
                        $display("FAIL addr_noburst got cyc=%0d tr=%b hb=%b sel=%b beat=%0d want tr=10 hb=000 sel=%b beat=%0d",
                                 cyc, b1.HTRANS, b1.HBURST, b1.Sel, b1.AddrBeat, a.sel, a.beat);
                    end
                end
            end
            if (b0.IFUDone || b0.LSUDone || b1.IFUDone || b1.LSUDone) begin
                n_cmp++;
                if (dq.size() == 0) begin
                    n_bad++;
                    $display("FAIL done_unexpected cyc=%0d d0=%b%b d1=%b%b", cyc,
                             b0.LSUDone, b0.IFUDone, b1.LSUDone, b1.IFUDone);
                end else begin
                    d = dq.pop_front();
                    if (cyc != d.cyc || b0.LSUDone != d.sel || b0.IFUDone != !d.sel ||
                        b1.LSUDone != d.sel || b1.IFUDone != !d.sel) begin
                        n_bad++;
                        $display("FAIL done got cyc=%0d d0(l,i)=%b%b d1(l,i)=%b%b want cyc=%0d lsu=%b",
                                 cyc, b0.LSUDone, b0.IFUDone, b1.LSUDone, b1.IFUDone, d.cyc, d.sel);
                    end
                end
                if (b0.IFUDone) saw_ifu = 1'b1;
                if (b0.LSUDone) saw_lsu = 1'b1;
            end
        end
    end

    // Requester agents: each raises its request ifu_n / lsu_n times back to
    // back, dropping it the cycle after its last Done. HREADY is pulled low
    // for st_len cycles starting st_off cycles after the request cycle.
    task automatic run(input int ifu_n, input logic ifu_b, input int lsu_n, input logic lsu_b,
                       input int st_off, input int st_len, input int budget);
        int t0, il, ll, k;
        t0 = cyc; il = ifu_n; ll = lsu_n; k = 0;
        saw_ifu = 1'b0; saw_lsu = 1'b0;
        IFUBurst = ifu_b; LSUBurst = lsu_b;
        IFUReq = (il > 0); LSUReq = (ll > 0);
        while ((IFUReq || LSUReq) && k < budget) begin
            @(posedge clk); #1;
            k++;
            if (saw_ifu) begin saw_ifu = 1'b0; il--; if (il == 0) IFUReq = 1'b0; end
            if (saw_lsu) begin saw_lsu = 1'b0; ll--; if (ll == 0) LSUReq = 1'b0; end
            HREADY = !(cyc >= t0 + st_off && cyc < t0 + st_off + st_len);
        end
        HREADY = 1'b1;
        if (IFUReq || LSUReq) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout cyc=%0d ifu_left=%0d lsu_left=%0d want 0", cyc, il, ll);
            IFUReq = 1'b0; LSUReq = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        // Reset values (reset still asserted)
        chk("rst_htrans", int'(b0.HTRANS), 0);
        chk("rst_hburst", int'(b0.HBURST), 0);
        chk("rst_sel", int'(b0.Sel), 0);
        chk("rst_addrbeat", int'(b0.AddrBeat), 0);
        chk("rst_grants", int'({b0.IFUGrant, b0.LSUGrant, b1.IFUGrant, b1.LSUGrant}), 0);
        chk("rst_dones", int'({b0.IFUDone, b0.LSUDone, b1.IFUDone, b1.LSUDone}), 0);
        reset = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // IFU single beat
        t = cyc;
        ea(t+1, NONSEQ, SINGLE, 1'b0, 4'd0);
        ed(t+2, 1'b0);
        run(1, 1'b0, 0, 1'b0, 0, 0, 20);

        // LSU 4-beat line fill
        t = cyc;
        ea(t+1, NONSEQ, INCR4, 1'b1, 4'd0);
        ea(t+2, SEQ,    INCR4, 1'b1, 4'd1);
        ea(t+3, SEQ,    INCR4, 1'b1, 4'd2);
        ea(t+4, SEQ,    INCR4, 1'b1, 4'd3);
        ed(t+5, 1'b1);
        run(0, 1'b0, 1, 1'b1, 0, 0, 20);

        // Same burst, HREADY low for two cycles on beat 2
        t = cyc;
        ea(t+1, NONSEQ, INCR4, 1'b1, 4'd0);
        ea(t+2, SEQ,    INCR4, 1'b1, 4'd1);
        ea(t+3, SEQ,    INCR4, 1'b1, 4'd2);
        ea(t+4, SEQ,    INCR4, 1'b1, 4'd2);
        ea(t+5, SEQ,    INCR4, 1'b1, 4'd2);
        ea(t+6, SEQ,    INCR4, 1'b1, 4'd3);
        ed(t+7, 1'b1);
        run(0, 1'b0, 1, 1'b1, 3, 2, 30);

        // Simultaneous: LSU single first, IFU 8-beat after LSUDone + one IDLE
        t = cyc;
        ea(t+1, NONSEQ, SINGLE, 1'b1, 4'd0);
        ed(t+2, 1'b1);
        ea(t+4, NONSEQ, INCR8, 1'b0, 4'd0);
        for (int i = 1; i < 8; i++) ea(t+4+i, SEQ, INCR8, 1'b0, 4'(i));
        ed(t+12, 1'b0);
        run(1, 1'b1, 1, 1'b0, 0, 0, 40);

        // Constant LSU pressure (4 back-to-back singles) against one IFU single
        t = cyc;
        ea(t+1, NONSEQ, SINGLE, 1'b1, 4'd0); ed(t+2, 1'b1);
        ea(t+4, NONSEQ, SINGLE, 1'b1, 4'd0); ed(t+5, 1'b1);
        ea(t+7, NONSEQ, SINGLE, 1'b1, 4'd0); ed(t+8, 1'b1);
`ifdef WALLY_ARB_STARVE_GUARD_EN
        ea(t+10, NONSEQ, SINGLE, 1'b0, 4'd0); ed(t+11, 1'b0);
        ea(t+13, NONSEQ, SINGLE, 1'b1, 4'd0); ed(t+14, 1'b1);
`else
        ea(t+10, NONSEQ, SINGLE, 1'b1, 4'd0); ed(t+11, 1'b1);
        ea(t+13, NONSEQ, SINGLE, 1'b0, 4'd0); ed(t+14, 1'b0);
`endif
        run(1, 1'b0, 4, 1'b0, 0, 0, 40);

        // Reset asserted while beat 1 is in its address phase
        t = cyc;
        ea(t+1, NONSEQ, INCR4, 1'b1, 4'd0);
        ea(t+2, SEQ,    INCR4, 1'b1, 4'd1);
        LSUBurst = 1'b1; LSUReq = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; LSUReq = 1'b0;
        @(negedge clk);
        chk("abort_htrans", int'(b0.HTRANS), 0);
        chk("abort_grants", int'({b0.IFUGrant, b0.LSUGrant, b1.IFUGrant, b1.LSUGrant}), 0);
        chk("abort_addrbeat", int'(b0.AddrBeat), 0);
        chk("abort_sel", int'(b0.Sel), 0);
        repeat (4) @(posedge clk);
        #1;

        // Anything left in the scoreboard never showed up
        chk("sb_addr_left", aq.size(), 0);
        chk("sb_done_left", dq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_arb_fsm.md
# ahb_arb_fsm

Two-requester AHB manager arbiter and transfer sequencer sitting in the external bus unit between the instruction-fetch (IFU) and load/store (LSU) bus interfaces and the single AHB manager port. It selects one requester, drives HTRANS/HBURST for a single transfer or a full cache-line burst sized from `cvw_t`, counts beats against HREADY, and signals completion. Address/data muxing is done outside by the `Sel` output.

## Interface
- `P`, `cvw_t`, default none: global configuration. Uses `AHBW`, `BURST_EN`, `ICACHE_LINELENINBITS`, `DCACHE_LINELENINBITS`.

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `IFUReq`  in  1  IFU transaction request; held until `IFUDone`
- `IFUBurst`  in  1  1 = line fill (`ICACHE_LINELENINBITS/AHBW` beats), 0 = single beat
- `IFUGrant`  out  1  IFU owns the bus
- `IFUDone`  out  1  one-cycle pulse when the IFU transaction's final data phase completes
- `LSUReq`, `LSUBurst`, `LSUGrant`, `LSUDone`: same as the IFU signals, with the D-cache line length
- `HREADY`  in  1  AHB subordinate ready
- `HTRANS`  out  2  00 IDLE, 10 NONSEQ, 11 SEQ
- `HBURST`  out  3  000 SINGLE, 011 INCR4, 101 INCR8, 111 INCR16
- `Sel`  out  1  0 = IFU, 1 = LSU; drives the address/data mux
- `AddrBeat`  out  4  beat index of the current address phase, used for address increment

## Operation
- States: IDLE, ADDR, DATA.
- IDLE
  - HTRANS = 00, both grants low.
  - If any request is present: select the winner, latch `Sel` and burst length (BeatsM1 = beats − 1), clear `AddrBeat`, go to ADDR.
  - Default priority: LSU wins over IFU.
- ADDR
  - The winner's grant is high.
  - HTRANS = NONSEQ on beat 0 and SEQ on later beats.
  - Each cycle with HREADY=1 accepts one address phase and increments `AddrBeat`.
  - When the address phase with `AddrBeat == BeatsM1` is accepted, go to DATA.
- DATA
  - HTRANS = 00; wait for the last data phase.
  - HREADY=1 pulses the winner's Done for that cycle, then go to IDLE.
  - Minimum one IDLE cycle between transactions.
- HBURST
  - Encoded from beat count: 1 → SINGLE; 4/8/16 → INCR4/8/16.
  - Any other beat count is illegal; the bench asserts against it.
- `P.BURST_EN = 0`
  - Bursts are issued as back-to-back SINGLE NONSEQ beats.
  - HBURST = 000 always.
  - Beat counting is unchanged.
- `AddrBeat` width is 4 bits, so at most 16 beats. `AddrBeat` does not wrap within a transaction.
- A request that deasserts before Done is a protocol violation and is ignored.
- A new request arriving while busy waits. Requests are re-arbitrated only in IDLE.

## Timing
- Reset values: state IDLE, HTRANS=00, HBURST=000, Sel=0, AddrBeat=0, grants=0, Dones=0, starvation counter=0.
- Reset asserted mid-transaction:
  - Next edge returns to IDLE; the outstanding AHB transfer is abandoned.
  - No Done pulse is issued for the abandoned transfer.
- Latency:
  - Request in IDLE at cycle t → grant and NONSEQ at t+1.
  - An N-beat transfer with HREADY always high → Done at t+N+1, IDLE at t+N+2.
- HREADY=0 in ADDR holds HTRANS, HBURST and `AddrBeat` stable.
- Simultaneous IFUReq and LSUReq in IDLE: LSU wins, unless the starvation guard forces IFU.
- Done and a new request in the same cycle: the new request is honoured next IDLE cycle.

## Configuration
- Macro `WALLY_ARB_STARVE_GUARD_EN`, when defined:
  - A 2-bit counter increments each time the LSU wins while IFUReq is pending.
  - When the counter is 3 and both requesters are present, IFU wins and the counter clears.
  - The counter also clears whenever IFU wins.
- When not defined: strict LSU priority; no counter logic is present.

## Structure
- Belongs in package `cvw`: an `ahbtrans_t` enum (IDLE/NONSEQ/SEQ) and `ahbburst_t` constants (SINGLE/INCR4/INCR8/INCR16).
- Local parameters computed in-module from `P`: `IBEATS`, `DBEATS`.
- One sub-module, `ahb_beat_ctr`: loadable 4-bit counter with an enable and a last-beat compare.

## Test plan
- IFUReq single beat, HREADY=1:
  - Cycle 1: NONSEQ, HBURST=000, Sel=0.
  - Cycle 2: IDLE.
  - IFUDone at cycle 2.
- LSUReq burst with 256-bit line, AHBW=64, BURST_EN=1:
  - HBURST=011; HTRANS NONSEQ,SEQ,SEQ,SEQ.
  - AddrBeat 0..3.
  - LSUDone 5 cycles after the request.
- Same burst with HREADY low for 2 cycles on beat 2:
  - AddrBeat stays 2 and HTRANS stays SEQ for those cycles.
  - Done is delayed by 2 cycles.
- Simultaneous IFUReq and LSUReq:
  - LSU is granted first; IFU is granted after LSUDone plus one IDLE cycle.
  - With the guard enabled, constant LSU pressure: IFU wins the 4th contended arbitration.
- BURST_EN=0, 4-beat request: four NONSEQ beats with HBURST=000; Done after the 4th data phase.
- Reset asserted in ADDR at beat 1:
  - Next cycle: HTRANS=00, grants=0, AddrBeat=0.
  - No Done pulse.
